// File: rtl/if_fetch.sv
// ----------------------------------------------------------------------------
// if_fetch : instruction-fetch stage feeding the IF/ID pipeline register.
//
// Owns the program counter and fetches one instruction at a time over a
// req/ack handshake. The fetched word is held and shown to if_id together
// with its PC. stallreq stays high until a valid instruction is held.
// Redirects come from ctrl (flush/new_pc) and from ID (branch_flag_i/target).
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   stall[5:0]                ctrl stall vector, only stall[0] is used here
//   flush, new_pc             ctrl redirect, taken even while stalled
//   branch_flag_i/target_i    ID-stage taken branch, taken only if unstalled
//   inst_req_o, inst_addr_o   memory request, address stable until ack
//   inst_ack_i, inst_data_i   single-cycle ack with data in the same cycle
//   pc_o, inst_o              PC/instruction presented to if_id
//   stallreq_o                fetch not ready, ctrl must stall
// ----------------------------------------------------------------------------
module if_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              inst_req_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_ack_i,
  input  logic [INST_W-1:0] inst_data_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              stallreq_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-3){1'b0}}, 3'b100};

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_addr;
  logic [INST_W-1:0] inst_buf;

  logic [ADDR_W-1:0] flush_pc;
  logic [ADDR_W-1:0] branch_pc;
  logic [ADDR_W-1:0] seq_pc;
  logic              unused_bits;

  // Redirect targets are word aligned; the sequential PC wraps naturally.
  assign flush_pc    = {new_pc[ADDR_W-1:2], 2'b00};
  assign branch_pc   = {branch_target_i[ADDR_W-1:2], 2'b00};
  assign seq_pc      = pc + PC_STEP;
  assign unused_bits = ^{stall[5:1], new_pc[1:0], branch_target_i[1:0]};

  // Fetch FSM with PC, request address and instruction buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      inst_buf <= {INST_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          if (flush) begin
            pc       <= flush_pc;
            req_addr <= flush_pc;
          end else begin
            req_addr <= pc;
          end
        end
        FETCH: begin
          if (flush) begin
            pc <= flush_pc;
            if (inst_ack_i) begin
              // Request completed in the same cycle: restart at the target.
              req_addr <= flush_pc;
              state    <= FETCH;
            end else begin
              // Request cannot be withdrawn: wait for its ack and drop it.
              state <= DRAIN;
            end
          end else if (inst_ack_i) begin
            inst_buf <= inst_data_i;
            state    <= VALID;
          end else begin
            state <= FETCH;
          end
        end
        DRAIN: begin
          if (flush) begin
            pc <= flush_pc;
          end
          if (inst_ack_i) begin
            // Stale data is discarded; refetch from the latest redirect.
            req_addr <= flush ? flush_pc : pc;
            state    <= FETCH;
          end else begin
            state <= DRAIN;
          end
        end
        VALID: begin
          if (flush) begin
            pc       <= flush_pc;
            req_addr <= flush_pc;
            state    <= FETCH;
          end else if (!stall[0]) begin
            if (branch_flag_i) begin
              pc       <= branch_pc;
              req_addr <= branch_pc;
            end else begin
              pc       <= seq_pc;
              req_addr <= seq_pc;
            end
            state <= FETCH;
          end else begin
            state <= VALID;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign inst_req_o  = (state == FETCH) || (state == DRAIN);
  assign inst_addr_o = req_addr;
  assign pc_o        = pc;
  assign inst_o      = (state == VALID) ? inst_buf : {INST_W{1'b0}};
  assign stallreq_o  = (state != VALID);

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_ack_i;
  logic [31:0] inst_data_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        stallreq_o;

  int n_cmp;
  int n_err;

  if_fetch #(
    .ADDR_W  (32),
    .INST_W  (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .new_pc         (new_pc),
    .branch_flag_i  (branch_flag_i),
    .branch_target_i(branch_target_i),
    .inst_req_o     (inst_req_o),
    .inst_addr_o    (inst_addr_o),
    .inst_ack_i     (inst_ack_i),
    .inst_data_i    (inst_data_i),
    .pc_o           (pc_o),
    .inst_o         (inst_o),
    .stallreq_o     (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of the behavioural instruction memory.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  task automatic clear_inputs();
    stall           = 6'd0;
    flush           = 1'b0;
    new_pc          = 32'd0;
    branch_flag_i   = 1'b0;
    branch_target_i = 32'd0;
    inst_ack_i      = 1'b0;
    inst_data_i     = 32'd0;
  endtask

  // Reset, release; afterwards the block sits in its first fetch of RESET_PC.
  task automatic release_reset();
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Reset, then redirect in the first cycle so the first fetch is at target.
  task automatic start_at(input logic [31:0] target);
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst    = 1'b1;
    flush  = 1'b1;
    new_pc = target;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    n_cmp++;
    if ({inst_req_o, inst_addr_o, pc_o, inst_o, stallreq_o} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: got req=%b addr=%h pc=%h inst=%h sreq=%b, expected 0/0/0/0/1",
               inst_req_o, inst_addr_o, pc_o, inst_o, stallreq_o);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] a, d;
    release_reset();
    for (int k = 0; k < 3; k++) begin
      a = 32'(k * 4);
      n_cmp++;
      if ({inst_req_o, inst_addr_o, stallreq_o, inst_o} !== {1'b1, a, 1'b1, 32'h0}) begin
        n_err++;
        $display("FAIL seq_fetch[%0d]: got req=%b addr=%h sreq=%b inst=%h, expected 1/%h/1/0",
                 k, inst_req_o, inst_addr_o, stallreq_o, inst_o, a);
      end
      d           = $urandom;
      inst_ack_i  = 1'b1;
      inst_data_i = d;
      @(negedge clk);
      inst_ack_i = 1'b0;
      n_cmp++;
      if ({inst_req_o, stallreq_o, pc_o, inst_o} !== {1'b0, 1'b0, a, d}) begin
        n_err++;
        $display("FAIL seq_valid[%0d]: got req=%b sreq=%b pc=%h inst=%h, expected 0/0/%h/%h",
                 k, inst_req_o, stallreq_o, pc_o, inst_o, a, d);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_slow_ack();
    logic [31:0] d;
    start_at(32'h0000_0010);
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if ({inst_req_o, inst_addr_o, stallreq_o, inst_o} !== {1'b1, 32'h10, 1'b1, 32'h0}) begin
        n_err++;
        $display("FAIL slow_hold[%0d]: got req=%b addr=%h sreq=%b inst=%h, expected 1/00000010/1/0",
                 c, inst_req_o, inst_addr_o, stallreq_o, inst_o);
      end
      if (c == 3) begin
        d           = $urandom;
        inst_ack_i  = 1'b1;
        inst_data_i = d;
      end
      @(negedge clk);
    end
    inst_ack_i = 1'b0;
    n_cmp++;
    if ({stallreq_o, pc_o, inst_o} !== {1'b0, 32'h10, d}) begin
      n_err++;
      $display("FAIL slow_valid: got sreq=%b pc=%h inst=%h, expected 0/00000010/%h",
               stallreq_o, pc_o, inst_o, d);
    end
  endtask

  task automatic test_branch();
    start_at(32'h0000_0020);
    inst_ack_i  = 1'b1;
    inst_data_i = mem_word(32'h20);
    @(negedge clk);
    inst_ack_i      = 1'b0;
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h0000_0103;
    @(negedge clk);
    branch_flag_i = 1'b0;
    n_cmp++;
    if ({inst_req_o, inst_addr_o, pc_o} !== {1'b1, 32'h100, 32'h100}) begin
      n_err++;
      $display("FAIL branch_redirect: got req=%b addr=%h pc=%h, expected 1/00000100/00000100",
               inst_req_o, inst_addr_o, pc_o);
    end
    inst_ack_i  = 1'b1;
    inst_data_i = mem_word(32'h100);
    @(negedge clk);
    inst_ack_i = 1'b0;
    n_cmp++;
    if ({stallreq_o, pc_o, inst_o} !== {1'b0, 32'h100, mem_word(32'h100)}) begin
      n_err++;
      $display("FAIL branch_valid: got sreq=%b pc=%h inst=%h, expected 0/00000100/%h",
               stallreq_o, pc_o, inst_o, mem_word(32'h100));
    end
  endtask

  task automatic test_stall_hold();
    logic [31:0] d;
    start_at(32'h0000_0040);
    d           = $urandom;
    inst_ack_i  = 1'b1;
    inst_data_i = d;
    @(negedge clk);
    inst_ack_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      stall           = 6'($urandom) | 6'b000001;
      branch_flag_i   = (c == 2);
      branch_target_i = 32'h0000_0300;
      @(negedge clk);
      n_cmp++;
      if ({stallreq_o, inst_req_o, pc_o, inst_o} !== {1'b0, 1'b0, 32'h40, d}) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got sreq=%b req=%b pc=%h inst=%h, expected 0/0/00000040/%h",
                 c, stallreq_o, inst_req_o, pc_o, inst_o, d);
      end
    end
    stall         = 6'd0;
    branch_flag_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({inst_req_o, inst_addr_o, pc_o} !== {1'b1, 32'h44, 32'h44}) begin
      n_err++;
      $display("FAIL stall_release: got req=%b addr=%h pc=%h, expected 1/00000044/00000044",
               inst_req_o, inst_addr_o, pc_o);
    end
  endtask

  task automatic test_flush();
    // Flush without ack: the old request drains before the target is fetched.
    start_at(32'h0000_0030);
    flush  = 1'b1;
    new_pc = 32'h0000_0200;
    @(negedge clk);
    flush = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_cmp++;
      if ({inst_req_o, inst_addr_o, stallreq_o, inst_o} !== {1'b1, 32'h30, 1'b1, 32'h0}) begin
        n_err++;
        $display("FAIL flush_drain[%0d]: got req=%b addr=%h sreq=%b inst=%h, expected 1/00000030/1/0",
                 c, inst_req_o, inst_addr_o, stallreq_o, inst_o);
      end
      @(negedge clk);
    end
    inst_ack_i  = 1'b1;
    inst_data_i = 32'hDEAD_BEEF;
    @(negedge clk);
    inst_ack_i = 1'b0;
    n_cmp++;
    if ({inst_req_o, inst_addr_o, stallreq_o, inst_o} !== {1'b1, 32'h200, 1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL flush_refetch: got req=%b addr=%h sreq=%b inst=%h, expected 1/00000200/1/0",
               inst_req_o, inst_addr_o, stallreq_o, inst_o);
    end
    inst_ack_i  = 1'b1;
    inst_data_i = mem_word(32'h200);
    @(negedge clk);
    inst_ack_i = 1'b0;
    n_cmp++;
    if ({stallreq_o, pc_o, inst_o} !== {1'b0, 32'h200, mem_word(32'h200)}) begin
      n_err++;
      $display("FAIL flush_valid: got sreq=%b pc=%h inst=%h, expected 0/00000200/%h",
               stallreq_o, pc_o, inst_o, mem_word(32'h200));
    end
    // Flush coincident with ack: next cycle already requests the target.
    start_at(32'h0000_0030);
    flush       = 1'b1;
    new_pc      = 32'h0000_0202;
    inst_ack_i  = 1'b1;
    inst_data_i = 32'hDEAD_BEEF;
    @(negedge clk);
    flush      = 1'b0;
    inst_ack_i = 1'b0;
    n_cmp++;
    if ({inst_req_o, inst_addr_o, pc_o, stallreq_o, inst_o} !== {1'b1, 32'h200, 32'h200, 1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL flush_with_ack: got req=%b addr=%h pc=%h sreq=%b inst=%h, expected 1/00000200/00000200/1/0",
               inst_req_o, inst_addr_o, pc_o, stallreq_o, inst_o);
    end
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] d;
    start_at(32'hFFFF_FFFC);
    d           = $urandom;
    inst_ack_i  = 1'b1;
    inst_data_i = d;
    @(negedge clk);
    inst_ack_i = 1'b0;
    n_cmp++;
    if ({stallreq_o, pc_o, inst_o} !== {1'b0, 32'hFFFF_FFFC, d}) begin
      n_err++;
      $display("FAIL wrap_valid: got sreq=%b pc=%h inst=%h, expected 0/fffffffc/%h",
               stallreq_o, pc_o, inst_o, d);
    end
    @(negedge clk);
    n_cmp++;
    if ({inst_req_o, inst_addr_o, pc_o} !== {1'b1, 32'h0, 32'h0}) begin
      n_err++;
      $display("FAIL wrap_advance: got req=%b addr=%h pc=%h, expected 1/00000000/00000000",
               inst_req_o, inst_addr_o, pc_o);
    end
    // Reset mid-fetch must act before any clock edge.
    start_at(32'h0000_0050);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({inst_req_o, inst_addr_o, pc_o, inst_o, stallreq_o} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b1}) begin
      n_err++;
      $display("FAIL async_reset: got req=%b addr=%h pc=%h inst=%h sreq=%b, expected 0/0/0/0/1",
               inst_req_o, inst_addr_o, pc_o, inst_o, stallreq_o);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({inst_req_o, inst_addr_o, pc_o} !== {1'b1, 32'h0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_refetch: got req=%b addr=%h pc=%h, expected 1/00000000/00000000",
               inst_req_o, inst_addr_o, pc_o);
    end
  endtask

  // Random traffic: the presented stream must follow the program-order rules
  // (redirects, +4 advance) and always carry the memory word of its PC.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] held_addr;
    logic        held;
    logic        valid_now;
    int          wait_cycles;
    int          presented;
    start_at(32'h0000_1000);
    exp_pc      = 32'h0000_1000;
    held        = 1'b0;
    held_addr   = 32'h0;
    wait_cycles = 0;
    presented   = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (held) begin
        n_cmp++;
        if ({inst_req_o, inst_addr_o} !== {1'b1, held_addr}) begin
          n_err++;
          $display("FAIL rand_req_stable@%0d: got req=%b addr=%h, expected 1/%h",
                   cyc, inst_req_o, inst_addr_o, held_addr);
        end
      end
      valid_now = !stallreq_o;
      n_cmp++;
      if (valid_now) begin
        presented++;
        wait_cycles = 0;
        if ({pc_o, inst_o} !== {exp_pc, mem_word(exp_pc)}) begin
          n_err++;
          $display("FAIL rand_present@%0d: got pc=%h inst=%h, expected %h/%h",
                   cyc, pc_o, inst_o, exp_pc, mem_word(exp_pc));
        end
      end else begin
        wait_cycles++;
        if (inst_o !== 32'h0) begin
          n_err++;
          $display("FAIL rand_bubble@%0d: got inst=%h, expected 00000000", cyc, inst_o);
        end
      end
      if (wait_cycles > 60) begin
        n_err++;
        $display("FAIL rand_progress@%0d: no instruction for %0d cycles, expected at most 60",
                 cyc, wait_cycles);
        break;
      end
      flush           = ($urandom_range(0, 19) == 0);
      new_pc          = $urandom;
      stall           = 6'($urandom);
      stall[0]        = ($urandom_range(0, 3) == 0);
      branch_flag_i   = ($urandom_range(0, 2) == 0);
      branch_target_i = $urandom;
      if (inst_req_o) begin
        inst_ack_i  = ($urandom_range(0, 2) == 0);
        inst_data_i = mem_word(inst_addr_o);
      end else begin
        inst_ack_i  = ($urandom_range(0, 7) == 0);
        inst_data_i = $urandom;
      end
      held      = inst_req_o && !inst_ack_i;
      held_addr = inst_addr_o;
      if (flush)
        exp_pc = {new_pc[31:2], 2'b00};
      else if (valid_now && !stall[0])
        exp_pc = branch_flag_i ? {branch_target_i[31:2], 2'b00} : exp_pc + 32'd4;
      @(negedge clk);
    end
    clear_inputs();
    n_cmp++;
    if (presented < 40) begin
      n_err++;
      $display("FAIL rand_throughput: got %0d instructions, expected at least 40", presented);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    clear_inputs();
    test_reset();
    test_sequential();
    test_slow_ack();
    test_branch();
    test_stall_hold();
    test_flush();
    test_wrap_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
